// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO write-side logic.
package fifo_pkg;

   // Write scheduler states
   typedef enum logic [1:0] {
      SCHED_RUN   = 2'd0,
      SCHED_FLUSH = 2'd1,
      SCHED_WAIT  = 2'd2,
      SCHED_DONE  = 2'd3
   } sched_state_t;

   // Width of the saturating accepted-write counter
   localparam int unsigned WR_COUNT_W = 16;

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational rotating-priority picker. The search starts one past ptr_i and
// wraps; wrap-around is handled by scanning a doubled request vector whose
// lower copy has the bits below the start position masked off.
module fifo_rr_pick
   import fifo_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               any_o
);

   localparam int N = int'(NUM_REQ);

   logic [2*NUM_REQ-1:0] dbl;
   int                   start;
   logic                 found;
   logic [IDX_W-1:0]     idx;

   // Build masked doubled vector, take the lowest set bit, fold index back
   always_comb begin
      start = (int'(ptr_i) == N - 1) ? 0 : int'(ptr_i) + 1;
      dbl   = '0;
      for (int i = 0; i < N; i++) begin
         dbl[i]     = req_i[i] && (i >= start);
         dbl[i + N] = req_i[i];
      end
      found = 1'b0;
      idx   = '0;
      for (int j = 0; j < 2 * N; j++) begin
         if (!found && dbl[j]) begin
            found = 1'b1;
            idx   = (j >= N) ? IDX_W'(j - N) : IDX_W'(j);
         end
      end
      gnt_o = '0;
      for (int i = 0; i < N; i++) begin
         gnt_o[i] = found && (idx == IDX_W'(i));
      end
      idx_o = idx;
      any_o = found;
   end

endmodule

// File: rtl/fifo_wr_sched.sv
// Shares one FIFO write port among NUM_REQ producers with round-robin grant,
// and sequences FIFO flushes (quiesce, pulse, wait with timeout, acknowledge).
module fifo_wr_sched
   import fifo_pkg::*;
#(
   parameter int unsigned NUM_REQ       = 4,
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned FLUSH_TIMEOUT = 16,
   localparam int unsigned IDX_W        = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          n_rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          flush_req,
   output logic                          flush_done,
   output logic                          flush_err,
   output logic                          busy,
   output logic [IDX_W-1:0]              grant_id,
   output logic [WR_COUNT_W-1:0]         wr_count,
   input  logic                          fifo_full,
   input  logic                          fifo_flushed,
   output logic                          fifo_w_en,
   output logic [DATA_WIDTH-1:0]         fifo_w_data,
   output logic                          fifo_flush
);

   localparam int unsigned TMO_W = $clog2(FLUSH_TIMEOUT);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FLUSH_TIMEOUT - 1);

   sched_state_t          state_q, state_d;
   logic [IDX_W-1:0]      ptr_q, ptr_d;
   logic [IDX_W-1:0]      grant_id_q, grant_id_d;
   logic [WR_COUNT_W-1:0] wr_count_q, wr_count_d;
   logic                  flush_err_q, flush_err_d;
   logic [TMO_W-1:0]      tmo_q, tmo_d;

   logic [NUM_REQ-1:0] pick_gnt;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;
   logic               pick_en;
   logic [NUM_REQ-1:0] hs;

   fifo_rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req_i (req_valid),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   // Grant, write-port mux and status outputs; ready is gated by n_rst so
   // nothing is offered while reset is held
   always_comb begin
      pick_en     = n_rst && (state_q == SCHED_RUN) && !flush_req && !fifo_full;
      req_ready   = (pick_en && pick_any) ? pick_gnt : '0;
      hs          = req_valid & req_ready;
      fifo_w_en   = |hs;
      fifo_w_data = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         fifo_w_data = fifo_w_data | (req_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{hs[i]}});
      end
      fifo_flush = (state_q == SCHED_FLUSH);
      flush_done = (state_q == SCHED_DONE);
      busy       = (state_q != SCHED_RUN);
      flush_err  = flush_err_q;
      grant_id   = grant_id_q;
      wr_count   = wr_count_q;
   end

   // Next-state logic for the flush sequencer, pointer and counters
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      grant_id_d  = grant_id_q;
      wr_count_d  = wr_count_q;
      flush_err_d = flush_err_q;
      tmo_d       = tmo_q;
      unique case (state_q)
         SCHED_RUN: begin
            if (flush_req) begin
               state_d     = SCHED_FLUSH;
               flush_err_d = 1'b0;
            end else if (fifo_w_en) begin
               ptr_d      = pick_idx;
               grant_id_d = pick_idx;
               if (wr_count_q != '1) begin
                  wr_count_d = wr_count_q + 1'b1;
               end
            end
         end
         SCHED_FLUSH: begin
            wr_count_d = '0;
            tmo_d      = '0;
            state_d    = SCHED_WAIT;
         end
         SCHED_WAIT: begin
            // A completion on the last allowed cycle still counts as success
            if (fifo_flushed) begin
               state_d = SCHED_DONE;
            end else if (tmo_q == TMO_LAST) begin
               flush_err_d = 1'b1;
               state_d     = SCHED_DONE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         SCHED_DONE: begin
            state_d = SCHED_RUN;
         end
         default: begin
            state_d = SCHED_RUN;
         end
      endcase
   end

   // State registers; pointer resets to the last index so requester 0 wins first
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= SCHED_RUN;
         ptr_q       <= IDX_W'(NUM_REQ - 1);
         grant_id_q  <= '0;
         wr_count_q  <= '0;
         flush_err_q <= 1'b0;
         tmo_q       <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         grant_id_q  <= grant_id_d;
         wr_count_q  <= wr_count_d;
         flush_err_q <= flush_err_d;
         tmo_q       <= tmo_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_sched.sv
// Directed bench for fifo_wr_sched: arbitration order, back-pressure,
// flush sequencing, timeout and reset during a flush.
module tb_fifo_wr_sched;

   localparam int unsigned NUM_REQ       = 4;
   localparam int unsigned DATA_WIDTH    = 8;
   localparam int unsigned FLUSH_TIMEOUT = 16;

   logic        clk;
   logic        n_rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        flush_req;
   logic        flush_done;
   logic        flush_err;
   logic        busy;
   logic [1:0]  grant_id;
   logic [15:0] wr_count;
   logic        fifo_full;
   logic        fifo_flushed;
   logic        fifo_w_en;
   logic [7:0]  fifo_w_data;
   logic        fifo_flush;

   int n_cmp = 0;
   int n_err = 0;

   fifo_wr_sched #(
      .NUM_REQ       (NUM_REQ),
      .DATA_WIDTH    (DATA_WIDTH),
      .FLUSH_TIMEOUT (FLUSH_TIMEOUT)
   ) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .flush_req    (flush_req),
      .flush_done   (flush_done),
      .flush_err    (flush_err),
      .busy         (busy),
      .grant_id     (grant_id),
      .wr_count     (wr_count),
      .fifo_full    (fifo_full),
      .fifo_flushed (fifo_flushed),
      .fifo_w_en    (fifo_w_en),
      .fifo_w_data  (fifo_w_data),
      .fifo_flush   (fifo_flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 time unit later
   initial begin
      n_rst        = 1'b0;
      req_valid    = 4'b1111;
      req_data     = 32'h4433_2211;
      flush_req    = 1'b0;
      fifo_full    = 1'b0;
      fifo_flushed = 1'b0;
      #1;
      check_eq("rst_ready", 32'(req_ready), 32'h0);
      check_eq("rst_w_en", 32'(fifo_w_en), 32'h0);
      check_eq("rst_busy", 32'(busy), 32'h0);
      check_eq("rst_flush", 32'(fifo_flush), 32'h0);
      check_eq("rst_done", 32'(flush_done), 32'h0);
      check_eq("rst_err", 32'(flush_err), 32'h0);
      check_eq("rst_gid", 32'(grant_id), 32'h0);
      check_eq("rst_cnt", 32'(wr_count), 32'h0);
      @(negedge clk);
      @(negedge clk);
      n_rst = 1'b1;

      // All four requesting: strict rotation 0,1,2,3,0,1,2,3
      for (int k = 0; k < 8; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         if (k > 0) check_eq("rot_gid", 32'(grant_id), 32'((k - 1) % 4));
         check_eq("rot_ready", 32'(req_ready), 32'(1 << (k % 4)));
         check_eq("rot_w_en", 32'(fifo_w_en), 32'h1);
         check_eq("rot_data", 32'(fifo_w_data), 32'(8'h11 * ((k % 4) + 1)));
      end
      @(negedge clk);
      #1;
      check_eq("rot_gid_last", 32'(grant_id), 32'h3);
      check_eq("rot_cnt", 32'(wr_count), 32'd8);

      // Move pointer to 1, then alternate between 3 and 1
      req_valid = 4'b0010;
      #1;
      check_eq("sp1_ready", 32'(req_ready), 32'b0010);
      @(negedge clk);
      req_valid = 4'b1010;
      #1;
      check_eq("alt_ready0", 32'(req_ready), 32'b1000);
      check_eq("alt_data0", 32'(fifo_w_data), 32'h44);
      @(negedge clk);
      #1;
      check_eq("alt_gid0", 32'(grant_id), 32'h3);
      check_eq("alt_ready1", 32'(req_ready), 32'b0010);
      @(negedge clk);
      #1;
      check_eq("alt_gid1", 32'(grant_id), 32'h1);
      check_eq("alt_ready2", 32'(req_ready), 32'b1000);
      @(negedge clk);
      #1;
      check_eq("alt_gid2", 32'(grant_id), 32'h3);
      check_eq("alt_cnt", 32'(wr_count), 32'd12);

      // Back-pressure for three cycles
      req_valid = 4'b1111;
      fifo_full = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         check_eq("full_ready", 32'(req_ready), 32'h0);
         check_eq("full_w_en", 32'(fifo_w_en), 32'h0);
         check_eq("full_data", 32'(fifo_w_data), 32'h0);
         check_eq("full_gid", 32'(grant_id), 32'h3);
      end
      @(negedge clk);
      fifo_full = 1'b0;
      #1;
      check_eq("full_cnt", 32'(wr_count), 32'd12);
      check_eq("resume_ready", 32'(req_ready), 32'b0001);
      @(negedge clk);
      #1;
      check_eq("resume_gid", 32'(grant_id), 32'h0);
      check_eq("resume_cnt", 32'(wr_count), 32'd13);

      // Flush with requests active; completion two cycles into WAIT
      flush_req = 1'b1;
      #1;
      check_eq("fl_req_ready", 32'(req_ready), 32'h0);
      check_eq("fl_req_w_en", 32'(fifo_w_en), 32'h0);
      check_eq("fl_req_busy", 32'(busy), 32'h0);
      @(negedge clk);
      flush_req = 1'b0;
      #1;
      check_eq("fl_pulse", 32'(fifo_flush), 32'h1);
      check_eq("fl_busy", 32'(busy), 32'h1);
      check_eq("fl_ready", 32'(req_ready), 32'h0);
      check_eq("fl_cnt_hold", 32'(wr_count), 32'd13);
      @(negedge clk);
      #1;
      check_eq("wait_pulse_off", 32'(fifo_flush), 32'h0);
      check_eq("wait_ready", 32'(req_ready), 32'h0);
      check_eq("wait_cnt_clr", 32'(wr_count), 32'h0);
      @(negedge clk);
      fifo_flushed = 1'b1;
      #1;
      check_eq("wait_done_lo", 32'(flush_done), 32'h0);
      @(negedge clk);
      fifo_flushed = 1'b0;
      #1;
      check_eq("done_pulse", 32'(flush_done), 32'h1);
      check_eq("done_ready", 32'(req_ready), 32'h0);
      check_eq("done_busy", 32'(busy), 32'h1);
      @(negedge clk);
      #1;
      check_eq("post_done", 32'(flush_done), 32'h0);
      check_eq("post_busy", 32'(busy), 32'h0);
      check_eq("post_err", 32'(flush_err), 32'h0);
      check_eq("post_ready", 32'(req_ready), 32'b0010);
      @(negedge clk);
      req_valid = 4'b0000;
      #1;
      check_eq("post_gid", 32'(grant_id), 32'h1);
      check_eq("post_cnt", 32'(wr_count), 32'h1);

      // Flush that times out after FLUSH_TIMEOUT WAIT cycles
      flush_req = 1'b1;
      @(negedge clk);
      flush_req = 1'b0;
      #1;
      check_eq("to_pulse", 32'(fifo_flush), 32'h1);
      for (int w = 0; w < 16; w++) begin
         @(negedge clk);
         #1;
         check_eq("to_wait_done", 32'(flush_done), 32'h0);
         check_eq("to_wait_err", 32'(flush_err), 32'h0);
      end
      @(negedge clk);
      #1;
      check_eq("to_done", 32'(flush_done), 32'h1);
      check_eq("to_err", 32'(flush_err), 32'h1);
      @(negedge clk);
      #1;
      check_eq("to_run_busy", 32'(busy), 32'h0);
      check_eq("to_err_sticky", 32'(flush_err), 32'h1);
      flush_req = 1'b1;
      @(negedge clk);
      flush_req = 1'b0;
      #1;
      check_eq("err_clear", 32'(flush_err), 32'h0);

      // Completion on the final WAIT cycle beats the timeout
      for (int w = 0; w < 16; w++) begin
         @(negedge clk);
         if (w == 15) fifo_flushed = 1'b1;
         #1;
         check_eq("edge_wait_done", 32'(flush_done), 32'h0);
      end
      @(negedge clk);
      fifo_flushed = 1'b0;
      #1;
      check_eq("edge_done", 32'(flush_done), 32'h1);
      check_eq("edge_err", 32'(flush_err), 32'h0);
      @(negedge clk);
      #1;
      check_eq("edge_busy", 32'(busy), 32'h0);

      // Reset asserted in WAIT abandons the flush
      req_valid = 4'b1111;
      flush_req = 1'b1;
      @(negedge clk);
      flush_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check_eq("mid_busy", 32'(busy), 32'h1);
      n_rst = 1'b0;
      #1;
      check_eq("mr_busy", 32'(busy), 32'h0);
      check_eq("mr_ready", 32'(req_ready), 32'h0);
      check_eq("mr_w_en", 32'(fifo_w_en), 32'h0);
      check_eq("mr_flush", 32'(fifo_flush), 32'h0);
      check_eq("mr_done", 32'(flush_done), 32'h0);
      check_eq("mr_gid", 32'(grant_id), 32'h0);
      check_eq("mr_cnt", 32'(wr_count), 32'h0);
      @(negedge clk);
      n_rst = 1'b1;
      #1;
      check_eq("mr_first", 32'(req_ready), 32'b0001);
      check_eq("mr_first_data", 32'(fifo_w_data), 32'h11);
      @(negedge clk);
      req_valid = 4'b0000;
      #1;
      check_eq("mr_gid0", 32'(grant_id), 32'h0);
      check_eq("mr_cnt1", 32'(wr_count), 32'h1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         check_eq("mr_no_done", 32'(flush_done), 32'h0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
